regfile_2r1w_sb: RTL
====================

// Module: regfile_2r1w_sb
// PURPOSE
//  Parametrised datapath register file: NREGS x WIDTH storage, one write port, two
//  independent read ports (A/B operands), optional write-to-read bypass, and a per-register
//  busy scoreboard. Sits between the instruction decoder (locks) and the ALU/writeback path.
//  Successor to the 8x16 1R1W regfile; adds async reset, second read port, bypass, scoreboard.
// PARAMETERS
//  WIDTH      16  data width of each register
//  AW          3  register index width; NREGS = 2**AW
//  BYPASS      1  1: same-cycle write data forwarded to read ports; 0: reads show stored value
//  RESET_VAL   0  value loaded into every register on reset (WIDTH bits)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  data_in    in   WIDTH     write data
//  writenum   in   AW        write register index
//  write      in   1         write enable, sampled on clk rise
//  readnum_a  in   AW        read port A index
//  readnum_b  in   AW        read port B index
//  data_out_a out  WIDTH     read port A data (combinational)
//  data_out_b out  WIDTH     read port B data (combinational)
//  lock       in   1         mark register locknum busy (pending producer), sampled on clk rise
//  locknum    in   AW        register index to lock
//  busy_a     out  1         register readnum_a has a pending producer
//  busy_b     out  1         register readnum_b has a pending producer
//  busy_vec   out  NREGS     registered scoreboard, bit i = register i busy
//  lock_err   out  1         one-cycle pulse: lock issued to an already-busy register
// BEHAVIOUR
//  - Reset (async, any time incl. mid-write): all regs <= RESET_VAL, busy_vec <= 0,
//    lock_err <= 0. Outputs valid immediately after reset asserts; no clk edge required.
//  - Write: on clk rise with write=1, R[writenum] <= data_in; write=0 leaves all regs unchanged.
//  - Read: data_out_x = R[readnum_x], combinational, zero latency. Both ports may address the
//    same register. X on readnum_x may propagate X to data_out_x.
//  - Bypass (BYPASS=1): if write=1 and writenum==readnum_x, data_out_x = data_in in the same
//    cycle. BYPASS=0: new value visible only after the clk edge.
//  - Scoreboard, per register i on clk rise:
//      lock & locknum==i            -> busy[i] <= 1 (wins over a same-cycle write to i)
//      else write & writenum==i     -> busy[i] <= 0
//      else                         -> hold
//  - Write to a non-busy register is legal; data stored, busy stays 0.
//  - busy_x = busy[readnum_x] & ~(BYPASS & write & writenum==readnum_x & ~(lock & locknum==readnum_x)).
//  - lock_err: registered; <= 1 for exactly one cycle after a clk rise where lock=1 and
//    busy[locknum]=1 and not (write & writenum==locknum). Lock still takes effect (busy stays 1).
//  - Lock and write to different registers in the same cycle are independent.
//  - Index wrap: indices are exactly AW bits; no out-of-range access possible.
// TESTING
//  1. Assert reset mid-cycle after writing 5->R0 -> data_out_a=0, busy_vec=0 before next clk edge.
//  2. Write 5->R0, 7->R1, 12->R7; readnum_a=0, readnum_b=7 -> data_out_a=5, data_out_b=12;
//     write=0 with data_in=3, writenum=1 -> R1 still 7.
//  3. BYPASS=1: write=1, writenum=2, data_in=9, readnum_a=2 before the edge -> data_out_a=9,
//     busy_a=0; BYPASS=0 same stimulus -> data_out_a=old R2 until the edge, 9 after.
//  4. lock R3 -> busy_vec=8'h08, busy_b=1 for readnum_b=3; write 4->R3 -> busy_vec=0, R3=4.
//  5. Same cycle lock R3 + write R3=6 -> R3=6, busy[3]=1, lock_err=0; lock R3 again -> lock_err=1
//     for one cycle, busy[3] remains 1.
//  6. Parameter sweep WIDTH=32, AW=4: write 32'hDEADBEEF->R15, read both ports -> 32'hDEADBEEF.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with optional write-to-read bypass and a
// per-register busy scoreboard for tracking pending producers.
module regfile_2r1w_sb #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      AW        = 3,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [AW-1:0]       writenum,
  input  logic                write,
  input  logic [AW-1:0]       readnum_a,
  input  logic [AW-1:0]       readnum_b,
  output logic [WIDTH-1:0]    data_out_a,
  output logic [WIDTH-1:0]    data_out_b,
  input  logic                lock,
  input  logic [AW-1:0]       locknum,
  output logic                busy_a,
  output logic                busy_b,
  output logic [(2**AW)-1:0]  busy_vec,
  output logic                lock_err
);

  localparam int unsigned NREGS = 2 ** AW;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_lock_err;

  logic w_byp_a, w_byp_b;
  logic w_lock_a, w_lock_b;
  logic w_lock_hits_busy;

  assign w_lock_hits_busy = lock & r_busy[locknum] & ~(write & (writenum == locknum));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_busy     <= '0;
      r_lock_err <= 1'b0;
    end else begin
      if (write) begin
        r_regs[writenum] <= data_in;
      end
      // A lock takes priority over a same-cycle write retiring the same register.
      for (int i = 0; i < NREGS; i++) begin
        if (lock && (locknum == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (write && (writenum == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
      r_lock_err <= w_lock_hits_busy;
    end
  end

  always_comb begin
    w_byp_a  = BYPASS && write && (writenum == readnum_a);
    w_byp_b  = BYPASS && write && (writenum == readnum_b);
    w_lock_a = lock && (locknum == readnum_a);
    w_lock_b = lock && (locknum == readnum_b);

    data_out_a = w_byp_a ? data_in : r_regs[readnum_a];
    data_out_b = w_byp_b ? data_in : r_regs[readnum_b];

    // A forwarded write clears the busy view unless a new lock re-arms it.
    busy_a = r_busy[readnum_a] & ~(w_byp_a & ~w_lock_a);
    busy_b = r_busy[readnum_b] & ~(w_byp_b & ~w_lock_b);
  end

  assign busy_vec = r_busy;
  assign lock_err = r_lock_err;

endmodule
